// File: rtl/event_encoder8to3.sv
// Sequential 8-to-3 event encoder: latches request-line events into a pending
// vector and streams their indices over valid/ready. Optional macro
// EVENT_ENC_ROUND_ROBIN_EN switches selection from fixed priority to round-robin.
module event_encoder8to3 #(
  parameter bit EDGE_DET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] d,
  input  logic       ovf_clr,
  input  logic       ready,
  output logic [2:0] a,
  output logic       valid,
  output logic [7:0] pending,
  output logic       ovf
);

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    d_q;
  logic            ovf_q, ovf_d;

  logic [N-1:0]    ev;
  logic [N-1:0]    served;
  logic [N-1:0]    rem;
  logic            hs;
  logic [AW-1:0]   idle_start;
  logic [AW-1:0]   hs_start;

  // First set bit found scanning downward from start, wrapping modulo 8.
  function automatic logic [AW-1:0] pick(input logic [N-1:0] vec,
                                         input logic [AW-1:0] start);
    logic [AW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = start - AW'(i);
      if (!found && vec[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

`ifdef EVENT_ENC_ROUND_ROBIN_EN
  logic [AW-1:0] last_q, last_d;

  always_comb begin
    last_d     = hs ? a_q : last_q;
    idle_start = last_q - AW'(1);
    hs_start   = a_q - AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= '0;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    idle_start = AW'(N - 1);
    hs_start   = AW'(N - 1);
  end
`endif

  // Event capture, drain of the served line and sticky overflow.
  always_comb begin
    if (EDGE_DET) ev = d & ~d_q & {N{en}};
    else          ev = d & {N{en}};
    hs        = (state_q == ST_PRESENT) & ready;
    served    = hs ? (N'(1) << a_q) : '0;
    rem       = pending_q & ~served;
    pending_d = rem | ev;
    ovf_d     = (ovf_q & ~ovf_clr) | (|(ev & rem));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          a_d     = pick(pending_q, idle_start);
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (hs) begin
          if (|rem) a_d     = pick(rem, hs_start);
          else      state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      pending_q <= '0;
      d_q       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      pending_q <= pending_d;
      d_q       <= d;
      ovf_q     <= ovf_d;
    end
  end

  assign a       = a_q;
  assign valid   = (state_q == ST_PRESENT);
  assign pending = pending_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_event_encoder8to3.sv
// Directed bench for event_encoder8to3: one edge-mode and one level-mode instance.
module tb_event_encoder8to3;

  logic       clk = 1'b0;
  logic       rst, ready, ovf_clr;
  logic       en_e, en_l;
  logic [7:0] d_e, d_l;
  logic [2:0] a_e, a_l;
  logic       valid_e, valid_l, ovf_e, ovf_l;
  logic [7:0] pend_e, pend_l;

  int checks   = 0;
  int failures = 0;

  logic [2:0] seq_a [0:5];
  logic [7:0] seq_p [0:3];

  always #5 clk = ~clk;

  event_encoder8to3 #(.EDGE_DET(1'b1)) u_edge (
    .clk(clk), .rst(rst), .en(en_e), .d(d_e), .ovf_clr(ovf_clr), .ready(ready),
    .a(a_e), .valid(valid_e), .pending(pend_e), .ovf(ovf_e)
  );

  event_encoder8to3 #(.EDGE_DET(1'b0)) u_level (
    .clk(clk), .rst(rst), .en(en_l), .d(d_l), .ovf_clr(ovf_clr), .ready(ready),
    .a(a_l), .valid(valid_l), .pending(pend_l), .ovf(ovf_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0; ovf_clr = 1'b0;
    en_e = 1'b1; en_l = 1'b1; d_e = '0; d_l = '0;
    step(); step();
    checks++; if (valid_e !== 1'b0) begin failures++; $display("FAIL rst_valid_e got=%0h exp=0", valid_e); end
    checks++; if (a_e !== 3'd0)     begin failures++; $display("FAIL rst_a_e got=%0h exp=0", a_e); end
    checks++; if (pend_e !== 8'h00) begin failures++; $display("FAIL rst_pend_e got=%0h exp=0", pend_e); end
    checks++; if (ovf_e !== 1'b0)   begin failures++; $display("FAIL rst_ovf_e got=%0h exp=0", ovf_e); end
    checks++; if (valid_l !== 1'b0 || a_l !== 3'd0 || pend_l !== 8'h00 || ovf_l !== 1'b0) begin
      failures++; $display("FAIL rst_level got=%0h/%0h/%0h/%0h exp=0/0/0/0", valid_l, a_l, pend_l, ovf_l);
    end
    rst = 1'b0;
    // Reset while a transfer is being held by backpressure.
    d_e = 8'h81;
    step(); step();
    checks++; if (valid_e !== 1'b1 || a_e !== 3'd7 || pend_e !== 8'h81) begin
      failures++; $display("FAIL mid_pre got=%0h/%0h/%0h exp=1/7/81", valid_e, a_e, pend_e);
    end
    rst = 1'b1; d_e = '0;
    step();
    checks++; if (valid_e !== 1'b0 || a_e !== 3'd0 || pend_e !== 8'h00 || ovf_e !== 1'b0) begin
      failures++; $display("FAIL mid_rst got=%0h/%0h/%0h/%0h exp=0/0/0/0", valid_e, a_e, pend_e, ovf_e);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_edge();
    ready = 1'b1; d_e = 8'h08;
    step();
    checks++; if (pend_e !== 8'h08 || valid_e !== 1'b0) begin
      failures++; $display("FAIL single_capture got=%0h/%0h exp=08/0", pend_e, valid_e);
    end
    step();
    checks++; if (valid_e !== 1'b1 || a_e !== 3'd3) begin
      failures++; $display("FAIL single_present got=%0h/%0h exp=1/3", valid_e, a_e);
    end
    step();
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h00 || a_e !== 3'd3) begin
      failures++; $display("FAIL single_done got=%0h/%0h/%0h exp=0/00/3", valid_e, pend_e, a_e);
    end
    d_e = '0;
    step();
  endtask

  task automatic test_priority();
    seq_a[0] = 3'd7; seq_a[1] = 3'd5; seq_a[2] = 3'd2; seq_a[3] = 3'd0;
    seq_p[0] = 8'hA5; seq_p[1] = 8'h25; seq_p[2] = 8'h05; seq_p[3] = 8'h01;
    ready = 1'b1; d_e = 8'hA5;
    step();
    checks++; if (pend_e !== 8'hA5) begin failures++; $display("FAIL prio_capture got=%0h exp=a5", pend_e); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (valid_e !== 1'b1 || a_e !== seq_a[k] || pend_e !== seq_p[k]) begin
        failures++; $display("FAIL prio_seq%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, valid_e, a_e, pend_e, seq_a[k], seq_p[k]);
      end
      step();
    end
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h00) begin
      failures++; $display("FAIL prio_end got=%0h/%0h exp=0/00", valid_e, pend_e);
    end
    d_e = '0;
    step();
  endtask

  task automatic test_backpressure();
    ready = 1'b0; d_e = 8'h10;
    step();
    d_e = 8'h00;
    step();
    d_e = 8'h10;
    step();
    checks++; if (valid_e !== 1'b1 || a_e !== 3'd4 || pend_e !== 8'h10 || ovf_e !== 1'b1) begin
      failures++; $display("FAIL bp_ovf got=%0h/%0h/%0h/%0h exp=1/4/10/1", valid_e, a_e, pend_e, ovf_e);
    end
    d_e = 8'h00; ovf_clr = 1'b1;
    step();
    checks++; if (ovf_e !== 1'b0 || valid_e !== 1'b1 || a_e !== 3'd4) begin
      failures++; $display("FAIL bp_clr got=%0h/%0h/%0h exp=0/1/4", ovf_e, valid_e, a_e);
    end
    // New event on the line being served in the same cycle keeps it pending.
    ovf_clr = 1'b0; ready = 1'b1; d_e = 8'h10;
    step();
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h10 || ovf_e !== 1'b0) begin
      failures++; $display("FAIL bp_served_event got=%0h/%0h/%0h exp=0/10/0", valid_e, pend_e, ovf_e);
    end
    d_e = 8'h00; ready = 1'b0;
    step();
    checks++; if (valid_e !== 1'b1 || a_e !== 3'd4) begin
      failures++; $display("FAIL bp_represent got=%0h/%0h exp=1/4", valid_e, a_e);
    end
    d_e = 8'h10; ovf_clr = 1'b1;
    step();
    checks++; if (ovf_e !== 1'b1) begin failures++; $display("FAIL bp_set_wins got=%0h exp=1", ovf_e); end
    d_e = 8'h00; ready = 1'b1;
    step();
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h00 || ovf_e !== 1'b0 || a_e !== 3'd4) begin
      failures++; $display("FAIL bp_drain got=%0h/%0h/%0h/%0h exp=0/00/0/4", valid_e, pend_e, ovf_e, a_e);
    end
    ovf_clr = 1'b0;
  endtask

  task automatic test_level_en();
    ready = 1'b1; en_l = 1'b0; d_l = 8'hFF;
    step(); step();
    checks++; if (pend_l !== 8'h00 || valid_l !== 1'b0) begin
      failures++; $display("FAIL lvl_gated got=%0h/%0h exp=00/0", pend_l, valid_l);
    end
    en_l = 1'b1; d_l = 8'h03;
    step();
    checks++; if (pend_l !== 8'h03) begin failures++; $display("FAIL lvl_capture got=%0h exp=03", pend_l); end
    en_l = 1'b0; d_l = 8'hFF;
    step();
    checks++; if (valid_l !== 1'b1 || a_l !== 3'd1 || pend_l !== 8'h03) begin
      failures++; $display("FAIL lvl_first got=%0h/%0h/%0h exp=1/1/03", valid_l, a_l, pend_l);
    end
    step();
    checks++; if (valid_l !== 1'b1 || a_l !== 3'd0 || pend_l !== 8'h01) begin
      failures++; $display("FAIL lvl_second got=%0h/%0h/%0h exp=1/0/01", valid_l, a_l, pend_l);
    end
    step();
    checks++; if (valid_l !== 1'b0 || pend_l !== 8'h00 || ovf_l !== 1'b0) begin
      failures++; $display("FAIL lvl_end got=%0h/%0h/%0h exp=0/00/0", valid_l, pend_l, ovf_l);
    end
    d_l = 8'h00; en_l = 1'b1;
  endtask

  task automatic test_round_robin();
    int n;
`ifdef EVENT_ENC_ROUND_ROBIN_EN
    seq_a[0] = 3'd7; seq_a[1] = 3'd6; seq_a[2] = 3'd0;
    seq_a[3] = 3'd7; seq_a[4] = 3'd6; seq_a[5] = 3'd0;
`else
    seq_a[0] = 3'd7; seq_a[1] = 3'd6; seq_a[2] = 3'd7;
    seq_a[3] = 3'd6; seq_a[4] = 3'd7; seq_a[5] = 3'd6;
`endif
    rst = 1'b1;
    step();
    rst = 1'b0; en_l = 1'b1; d_l = 8'hC1; ready = 1'b1;
    step();
    checks++; if (pend_l !== 8'hC1 || valid_l !== 1'b0) begin
      failures++; $display("FAIL rr_capture got=%0h/%0h exp=c1/0", pend_l, valid_l);
    end
    step();
    for (int k = 0; k < 6; k++) begin
      checks++; if (valid_l !== 1'b1 || a_l !== seq_a[k]) begin
        failures++; $display("FAIL rr_seq%0d got=%0h/%0h exp=1/%0h", k, valid_l, a_l, seq_a[k]);
      end
      step();
    end
    checks++; if (ovf_l !== 1'b1) begin failures++; $display("FAIL rr_ovf got=%0h exp=1", ovf_l); end
    d_l = 8'h00;
    n = 0;
    while ((valid_l !== 1'b0 || pend_l !== 8'h00) && n < 12) begin
      step();
      n++;
    end
    checks++; if (valid_l !== 1'b0 || pend_l !== 8'h00) begin
      failures++; $display("FAIL rr_drain got=%0h/%0h exp=0/00", valid_l, pend_l);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority();
    test_backpressure();
    test_level_en();
    test_round_robin();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
